uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer_pkg.sv | 25 ++
 rtl/uart_tx_serializer_if.sv | 23 ++
 rtl/uart_tx_serializer_timer.sv | 30 +++
 rtl/uart_tx_serializer.sv | 158 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter.
// Holds the FSM state enum, line levels and a parity helper.
package uart_pkg;

   localparam int   DATA_BITS   = 8;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Even parity is the plain XOR; odd inverts it.
   function automatic logic parity_of(
      input logic [DATA_BITS-1:0] d,
      input logic                 odd
   );
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: character load handshake and line outputs.
// master: XMitGo/TxData out; slave: TxEmpty/TxD/Busy/Overrun out.
interface uart_tx_serializer_if;
   import uart_pkg::*;

   logic                 XMitGo;
   logic [DATA_BITS-1:0] TxData;
   logic                 TxEmpty;
   logic                 TxD;
   logic                 Busy;
   logic                 Overrun;

   modport master (
      output XMitGo, TxData,
      input  TxEmpty, TxD, Busy, Overrun
   );

   modport slave (
      input  XMitGo, TxData,
      output TxEmpty, TxD, Busy, Overrun
   );

endinterface

// File: rtl/uart_tx_serializer_timer.sv
// uart_bit_timer: bit-period counter, bit_done pulses every CLKS_PER_BIT.
// Ports: clk, rst (sync, high), restart (zero the count), bit_done.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_done
);

   localparam int CW =
      (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: holding register + shifter UART transmitter.
// Ports: Enable (clock), Reset (sync, high), bus (slave modport).
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  Enable,
   input  logic                  Reset,
   uart_tx_serializer_if.slave   bus
);

   localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic       ODD       = (PARITY_ODD != 0);

   tx_state_t            state, state_nxt;
   logic [2:0]           idx, idx_nxt, idx_inc;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [DATA_BITS-1:0] thr, thr_nxt;
   logic                 full, full_nxt;
   logic                 txd, txd_nxt;
   logic                 ovr, ovr_nxt;
   logic                 load;
   logic                 restart;
   logic                 bit_done;

   // Timer is held at zero while idle so the start bit
   // gets a full period from the load edge.
   assign restart = (state == IDLE);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk      (Enable),
      .rst      (Reset),
      .restart  (restart),
      .bit_done (bit_done)
   );

   assign idx_inc = idx + 3'd1;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      thr_nxt   = thr;
      full_nxt  = full;
      txd_nxt   = txd;
      ovr_nxt   = 1'b0;
      load      = 1'b0;

      // A request against a full THR is dropped, including the
      // cycle in which the THR drains into the shifter.
      if (bus.XMitGo) begin
         if (full) begin
            ovr_nxt = 1'b1;
         end else begin
            thr_nxt  = bus.TxData;
            full_nxt = 1'b1;
         end
      end

      unique case (state)
         IDLE: begin
            txd_nxt = IDLE_LEVEL;
            if (full) load = 1'b1;
         end
         START: begin
            if (bit_done) begin
               state_nxt = DATA;
               idx_nxt   = 3'd0;
               txd_nxt   = shreg[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (idx == LAST_IDX) begin
                  idx_nxt = 3'd0;
                  if (PARITY_EN != 0) begin
                     state_nxt = PARITY;
                     txd_nxt   = parity_of(shreg, ODD);
                  end else begin
                     state_nxt = STOP;
                     txd_nxt   = IDLE_LEVEL;
                  end
               end else begin
                  idx_nxt = idx_inc;
                  txd_nxt = shreg[idx_inc];
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_nxt = STOP;
               idx_nxt   = 3'd0;
               txd_nxt   = IDLE_LEVEL;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (idx == LAST_STOP) begin
                  if (full) begin
                     load = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                     txd_nxt   = IDLE_LEVEL;
                  end
               end else begin
                  idx_nxt = idx_inc;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            txd_nxt   = IDLE_LEVEL;
         end
      endcase

      // Load never coincides with acceptance: it needs THR full.
      if (load) begin
         shreg_nxt = thr;
         full_nxt  = 1'b0;
         state_nxt = START;
         idx_nxt   = 3'd0;
         txd_nxt   = START_LEVEL;
      end
   end

   always_ff @(posedge Enable) begin
      if (Reset) begin
         state <= IDLE;
         idx   <= 3'd0;
         shreg <= '0;
         thr   <= '0;
         full  <= 1'b0;
         txd   <= IDLE_LEVEL;
         ovr   <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         shreg <= shreg_nxt;
         thr   <= thr_nxt;
         full  <= full_nxt;
         txd   <= txd_nxt;
         ovr   <= ovr_nxt;
      end
   end

   assign bus.TxD     = txd;
   assign bus.TxEmpty = ~full;
   assign bus.Busy    = (state != IDLE);
   assign bus.Overrun = ovr;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: three parameterisations driven in lockstep,
// checked by a frame-level model plus directed vectors.
module tb_uart_tx_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       go;
   logic [7:0] data;

   always #5 clk = ~clk;

   uart_tx_serializer_if b0();
   uart_tx_serializer_if b1();
   uart_tx_serializer_if b2();

   assign b0.XMitGo = go;
   assign b0.TxData = data;
   assign b1.XMitGo = go;
   assign b1.TxData = data;
   assign b2.XMitGo = go;
   assign b2.TxData = data;

   uart_tx_serializer #(
      .CLKS_PER_BIT(1), .PARITY_EN(0),
      .PARITY_ODD(0), .STOP_BITS(1)
   ) d0 (.Enable(clk), .Reset(rst), .bus(b0));

   uart_tx_serializer #(
      .CLKS_PER_BIT(1), .PARITY_EN(1),
      .PARITY_ODD(0), .STOP_BITS(1)
   ) d1 (.Enable(clk), .Reset(rst), .bus(b1));

   uart_tx_serializer #(
      .CLKS_PER_BIT(4), .PARITY_EN(1),
      .PARITY_ODD(1), .STOP_BITS(2)
   ) d2 (.Enable(clk), .Reset(rst), .bus(b2));

   logic [2:0] txd_o, emp_o, busy_o, ovr_o;
   assign txd_o[0]  = b0.TxD;
   assign txd_o[1]  = b1.TxD;
   assign txd_o[2]  = b2.TxD;
   assign emp_o[0]  = b0.TxEmpty;
   assign emp_o[1]  = b1.TxEmpty;
   assign emp_o[2]  = b2.TxEmpty;
   assign busy_o[0] = b0.Busy;
   assign busy_o[1] = b1.Busy;
   assign busy_o[2] = b2.Busy;
   assign ovr_o[0]  = b0.Overrun;
   assign ovr_o[1]  = b1.Overrun;
   assign ovr_o[2]  = b2.Overrun;

   localparam int CPB  [3] = '{1, 1, 4};
   localparam int PEN  [3] = '{0, 1, 1};
   localparam int PODD [3] = '{0, 0, 1};
   localparam int SB   [3] = '{1, 1, 2};

   int n_chk  = 0;
   int n_fail = 0;

   // Model: position (in clocks) inside the frame on the line,
   // -1 when idle, plus a one-deep holding register.
   int          m_pos  [3];
   bit          m_full [3];
   logic [7:0]  m_thr  [3];
   logic [11:0] m_fr   [3];
   bit          m_ovr  [3];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] mk_frame(int d, logic [7:0] c);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = c;
      if (PEN[d] != 0) f[9] = (^c) ^ (PODD[d] != 0);
      return f;
   endfunction

   function automatic int flen(int d);
      return (1 + 8 + PEN[d] + SB[d]) * CPB[d];
   endfunction

   function automatic logic m_txd(int d);
      if (m_pos[d] < 0) return 1'b1;
      return m_fr[d][m_pos[d] / CPB[d]];
   endfunction

   task automatic model_step();
      for (int d = 0; d < 3; d++) begin
         bit acc;
         int nxt;
         if (rst) begin
            m_pos[d]  = -1;
            m_full[d] = 1'b0;
            m_ovr[d]  = 1'b0;
            m_thr[d]  = 8'h00;
         end else begin
            m_ovr[d] = go && m_full[d];
            acc      = go && !m_full[d];
            nxt = (m_pos[d] < 0) ? -1 : m_pos[d] + 1;
            if (nxt >= flen(d)) nxt = -1;
            if (nxt < 0 && m_full[d]) begin
               m_fr[d]   = mk_frame(d, m_thr[d]);
               nxt       = 0;
               m_full[d] = 1'b0;
            end
            if (acc) begin
               m_full[d] = 1'b1;
               m_thr[d]  = data;
            end
            m_pos[d] = nxt;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("m_txd%0d", d), txd_o[d], m_txd(d));
         chk($sformatf("m_empty%0d", d), emp_o[d], !m_full[d]);
         chk($sformatf("m_busy%0d", d), busy_o[d], m_pos[d] >= 0);
         chk($sformatf("m_ovr%0d", d), ovr_o[d], m_ovr[d]);
      end
   endtask

   task automatic drive(input logic g, input logic [7:0] c,
                        input logic r);
      go   = g;
      data = c;
      rst  = r;
   endtask

   typedef struct {
      int          dut;
      logic [7:0]  c;
      int          nb;
      logic [11:0] bits;
   } vec_t;

   vec_t        tbl [6];
   int          dv;
   logic [19:0] bb;

   initial begin
      tbl[0] = '{0, 8'h55, 10, 12'b001010101010};
      tbl[1] = '{0, 8'hA3, 10, 12'b001101000110};
      tbl[2] = '{1, 8'h41, 11, 12'b010010000010};
      tbl[3] = '{1, 8'hFF, 11, 12'b010111111110};
      tbl[4] = '{2, 8'h00, 12, 12'b111000000000};
      tbl[5] = '{2, 8'h41, 12, 12'b111010000010};

      drive(1'b1, 8'hA5, 1'b1);
      tick();
      tick();
      chk("rst_txd", txd_o[0], 1);
      chk("rst_empty", emp_o[0], 1);
      chk("rst_busy", busy_o[0], 0);
      chk("rst_ovr", ovr_o[0], 0);
      drive(1'b0, 8'h00, 1'b0);
      tick();

      for (int i = 0; i < 6; i++) begin
         dv = tbl[i].dut;
         drive(1'b1, tbl[i].c, 1'b0);
         tick();
         for (int t = 1; t <= 60; t++) begin
            drive(1'b0, 8'($urandom), 1'b0);
            tick();
            if (t == 1) chk("vec_empty", emp_o[dv], 1);
            if ((t - 1) / CPB[dv] < tbl[i].nb)
               chk("vec_txd", txd_o[dv],
                   tbl[i].bits[(t - 1) / CPB[dv]]);
            else if (t == tbl[i].nb * CPB[dv] + 1)
               chk("vec_busy_end", busy_o[dv], 0);
         end
      end

      bb = {10'b1011010010, 10'b1010010000};
      drive(1'b1, 8'h48, 1'b0);
      tick();
      for (int t = 1; t <= 22; t++) begin
         if (t == 2) drive(1'b1, 8'h69, 1'b0);
         else drive(1'b0, 8'($urandom), 1'b0);
         tick();
         if (t <= 20) begin
            chk("b2b_txd", txd_o[0], bb[t - 1]);
            chk("b2b_busy", busy_o[0], 1);
         end else begin
            chk("b2b_idle", busy_o[0], 0);
         end
      end
      for (int t = 0; t < 80; t++) begin
         drive(1'b0, 8'h00, 1'b0);
         tick();
      end

      drive(1'b1, 8'h0F, 1'b0);
      tick();
      drive(1'b1, 8'hF0, 1'b0);
      tick();
      chk("ovr_pulse", ovr_o[0], 1);
      chk("ovr_empty", emp_o[0], 1);
      drive(1'b0, 8'h00, 1'b0);
      tick();
      chk("ovr_clear", ovr_o[0], 0);
      for (int t = 3; t <= 14; t++) tick();
      chk("ovr_one_frame", busy_o[0], 0);
      chk("ovr_line", txd_o[0], 1);
      for (int t = 0; t < 60; t++) tick();

      drive(1'b1, 8'hC3, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      tick();
      drive(1'b1, 8'h3C, 1'b0);
      tick();
      chk("mid_full", emp_o[0], 0);
      drive(1'b0, 8'h00, 1'b0);
      for (int t = 3; t <= 6; t++) tick();
      chk("mid_bit4", txd_o[0], 0);
      drive(1'b1, 8'hAA, 1'b1);
      tick();
      chk("mid_rst_txd", txd_o[0], 1);
      chk("mid_rst_empty", emp_o[0], 1);
      chk("mid_rst_busy", busy_o[0], 0);
      drive(1'b0, 8'h00, 1'b0);
      for (int t = 0; t < 40; t++) tick();
      chk("mid_no_frame", busy_o[0], 0);
      chk("mid_no_frame_d2", busy_o[2], 0);

      for (int t = 0; t < 4000; t++) begin
         drive($urandom_range(0, 3) == 0, 8'($urandom),
               $urandom_range(0, 299) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
